// File: rtl/dvi_timing_out.sv
// DVI raster timing generator that drains a 24-bit pixel FIFO, locking on frame boundaries.
// Optional colour-bar generator enabled with `define DVI_TEST_PATTERN_EN (adds test_mode input).
module dvi_timing_out #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
`ifdef DVI_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    input  logic [23:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_ren,
    output logic [23:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start,
    output logic        locked,
    output logic        underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_ST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_EN = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_ST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_EN = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);

    typedef enum logic {S_WAIT, S_RUN} state_t;

    state_t     state;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       act0, hs0, vs0, sof0, frame_end, test_on;
    logic       act1, hs1, vs1, sof1, pix_valid1;

`ifdef DVI_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'd80;
    logic [2:0] bar1;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = 24'hFFFFFF;
            3'd1:    bar_color = 24'hFFFF00;
            3'd2:    bar_color = 24'h00FFFF;
            3'd3:    bar_color = 24'h00FF00;
            3'd4:    bar_color = 24'hFF00FF;
            3'd5:    bar_color = 24'hFF0000;
            3'd6:    bar_color = 24'h0000FF;
            default: bar_color = 24'h000000;
        endcase
    endfunction

    assign test_on = test_mode;
`else
    assign test_on = 1'b0;
`endif

    assign act0      = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    assign hs0       = (h_cnt >= H_SYNC_ST) && (h_cnt < H_SYNC_EN);
    assign vs0       = (v_cnt >= V_SYNC_ST) && (v_cnt < V_SYNC_EN);
    assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign sof0      = (h_cnt == 10'd0) && (v_cnt == 10'd0) && (state == S_RUN) && !test_on;
    // Pops are suppressed while rst is held so a reset never consumes FIFO data.
    assign fifo_ren  = act0 && (state == S_RUN) && !fifo_empty && !rst && !test_on;
    assign locked    = (state == S_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_WAIT;
            underflow <= 1'b0;
        end else if (test_on) begin
            state <= S_WAIT;
        end else begin
            case (state)
                S_WAIT: if (frame_end && !fifo_empty) state <= S_RUN;
                S_RUN: begin
                    state <= S_RUN;
                    if (act0 && fifo_empty) underflow <= 1'b1;
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    // Two-stage output pipeline; rgb captures FIFO data one cycle after the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            act1        <= 1'b0;
            hs1         <= 1'b0;
            vs1         <= 1'b0;
            sof1        <= 1'b0;
            pix_valid1  <= 1'b0;
            de          <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
            rgb         <= '0;
`ifdef DVI_TEST_PATTERN_EN
            bar1        <= '0;
`endif
        end else begin
            act1        <= act0;
            hs1         <= hs0;
            vs1         <= vs0;
            sof1        <= sof0;
            pix_valid1  <= fifo_ren;
            de          <= act1;
            hsync       <= hs1 ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs1 ? SYNC_POL : ~SYNC_POL;
            frame_start <= sof1;
`ifdef DVI_TEST_PATTERN_EN
            bar1        <= 3'(h_cnt / BAR_W);
            if (test_mode) rgb <= act1 ? bar_color(bar1) : 24'h0;
            else           rgb <= pix_valid1 ? fifo_dout : 24'h0;
`else
            rgb         <= pix_valid1 ? fifo_dout : 24'h0;
`endif
        end
    end

endmodule

// File: tb/tb_dvi_timing_out.sv
// Self-checking bench for dvi_timing_out using a shrunken raster and a ramp-filled FIFO model.
module tb_dvi_timing_out;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int NTBL = 13;

    logic        clk;
    logic        rst;
    logic [23:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_ren;
    logic [23:0] rgb;
    logic        hsync, vsync, de, frame_start, locked, underflow;

    dvi_timing_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_ren(fifo_ren),
        .rgb(rgb), .hsync(hsync), .vsync(vsync), .de(de),
        .frame_start(frame_start), .locked(locked), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO holds an endless ramp 0,1,2,...; data appears the cycle after a pop.
    int unsigned fifo_ptr = 0;
    always @(posedge clk) begin
        if (fifo_ren) begin
            fifo_dout <= fifo_ptr[23:0];
            fifo_ptr  <= fifo_ptr + 1;
        end
    end

    typedef struct {
        int          h;
        int          v;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [23:0] rgb;
    } out_t;

    typedef struct {
        int   h;
        int   v;
        logic de;
        logic hs;
        logic vs;
    } vec_t;

    vec_t tbl [NTBL];
    int   tbl_hits [NTBL];

    out_t        pipe [$];
    int          mh, mv;
    bit          mlocked, munder;
    int unsigned mramp = 0;

    int checks = 0;
    int passes = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    task automatic modelReset();
        out_t r;
        r.h = -1; r.v = -1; r.de = 1'b0; r.hs = 1'b1; r.vs = 1'b1; r.fs = 1'b0; r.rgb = 24'h0;
        mh = 0; mv = 0; mlocked = 1'b0; munder = 1'b0;
        pipe.delete();
        pipe.push_back(r);
        pipe.push_back(r);
    endtask

    // One pixel clock: check what the DUT shows now, drive new inputs, advance the model.
    task automatic applyStimulus(input bit rst_v, input bit empty_v);
        out_t exp_r, nxt;
        bit   act, pop;
        exp_r = pipe.pop_front();
        checkOutput("de", 32'(de), 32'(exp_r.de));
        checkOutput("hsync", 32'(hsync), 32'(exp_r.hs));
        checkOutput("vsync", 32'(vsync), 32'(exp_r.vs));
        checkOutput("frame_start", 32'(frame_start), 32'(exp_r.fs));
        checkOutput("rgb", 32'(rgb), 32'(exp_r.rgb));
        checkOutput("locked", 32'(locked), 32'(mlocked));
        checkOutput("underflow", 32'(underflow), 32'(munder));
        for (int i = 0; i < NTBL; i++) begin
            if (tbl[i].h == exp_r.h && tbl[i].v == exp_r.v) begin
                tbl_hits[i]++;
                checkOutput("tbl_de", 32'(de), 32'(tbl[i].de));
                checkOutput("tbl_hsync", 32'(hsync), 32'(tbl[i].hs));
                checkOutput("tbl_vsync", 32'(vsync), 32'(tbl[i].vs));
            end
        end

        rst = rst_v;
        fifo_empty = empty_v;
        #1;
        act = (mh < HA) && (mv < VA);
        pop = !rst_v && mlocked && act && !empty_v;
        checkOutput("fifo_ren", 32'(fifo_ren), 32'(pop));

        nxt.h   = mh;
        nxt.v   = mv;
        nxt.de  = act;
        nxt.hs  = (mh >= HA + HF && mh < HA + HF + HS) ? 1'b0 : 1'b1;
        nxt.vs  = (mv >= VA + VF && mv < VA + VF + VS) ? 1'b0 : 1'b1;
        nxt.fs  = mlocked && mh == 0 && mv == 0;
        nxt.rgb = pop ? mramp[23:0] : 24'h0;
        if (pop) mramp++;

        if (rst_v) begin
            modelReset();
        end else begin
            pipe.push_back(nxt);
            if (mlocked && act && empty_v) munder = 1'b1;
            if (!mlocked && mh == HT - 1 && mv == VT - 1 && !empty_v) mlocked = 1'b1;
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv + 1) % VT;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int          n, de_cnt;
        int unsigned p0;
        bit          ren_seen;

        tbl[0]  = '{0,       0,       1'b1, 1'b1, 1'b1};
        tbl[1]  = '{HA-1,    0,       1'b1, 1'b1, 1'b1};
        tbl[2]  = '{HA,      0,       1'b0, 1'b1, 1'b1};
        tbl[3]  = '{HA+HF-1, 0,       1'b0, 1'b1, 1'b1};
        tbl[4]  = '{HA+HF,   0,       1'b0, 1'b0, 1'b1};
        tbl[5]  = '{HA+HF+HS-1, 0,    1'b0, 1'b0, 1'b1};
        tbl[6]  = '{HA+HF+HS, 0,      1'b0, 1'b1, 1'b1};
        tbl[7]  = '{HT-1,    VA-1,    1'b0, 1'b1, 1'b1};
        tbl[8]  = '{0,       VA,      1'b0, 1'b1, 1'b1};
        tbl[9]  = '{0,       VA+VF,   1'b0, 1'b1, 1'b0};
        tbl[10] = '{5,       VA+VF+VS-1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{0,       VA+VF+VS, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{HA+HF+1, VA+VF,   1'b0, 1'b0, 1'b0};
        for (int i = 0; i < NTBL; i++) tbl_hits[i] = 0;

        rst = 1'b1;
        fifo_empty = 1'b1;
        @(negedge clk);
        modelReset();
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);

        // Idle frame with an empty FIFO: timing runs, nothing is read.
        de_cnt = 0;
        ren_seen = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
            if (de) de_cnt++;
            if (fifo_ren) ren_seen = 1'b1;
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput("idle_de_count", 32'(de_cnt), 32'(HA * VA));
        checkOutput("idle_no_pop", 32'(ren_seen), 32'd0);
        checkOutput("idle_unlocked", 32'(locked), 32'd0);

        // Lock onto a full FIFO at the frame wrap.
        n = 0;
        while (!locked && n < 2 * FRAME) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        checkOutput("lock_reached", 32'(locked), 32'd1);
        n = 0;
        while (!frame_start && n < 8) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        checkOutput("sof_seen", 32'(frame_start), 32'd1);
        checkOutput("sof_de", 32'(de), 32'd1);
        checkOutput("sof_rgb", 32'(rgb), 32'd0);
        p0 = fifo_ptr;
        applyStimulus(1'b0, 1'b0);
        checkOutput("pix1_rgb", 32'(rgb), 32'd1);
        n = 1;
        while (!frame_start && n < 2 * FRAME) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        checkOutput("frame_period", 32'(n), 32'(FRAME));
        checkOutput("pops_per_frame", fifo_ptr - p0, 32'(HA * VA));
        checkOutput("no_underflow_yet", 32'(underflow), 32'd0);

        // Five empty active cycles mid-line.
        n = 0;
        while (!(mh == 5 && mv == 1) && n < 2 * FRAME) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        p0 = fifo_ptr;
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b1);
        checkOutput("underrun_no_pops", fifo_ptr - p0, 32'd0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("underflow_set", 32'(underflow), 32'd1);
        for (int c = 0; c < FRAME; c++) applyStimulus(1'b0, 1'b0);
        checkOutput("underflow_sticky", 32'(underflow), 32'd1);

        // Random FIFO availability across several frames.
        for (int c = 0; c < 4 * FRAME; c++)
            applyStimulus(1'b0, ($urandom_range(0, 7) == 0));

        // Reset mid-frame while locked, then relock exactly one frame later.
        n = 0;
        while (!(mh == HA / 2 && mv == VA / 2) && n < 2 * FRAME) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        checkOutput("pre_reset_locked", 32'(locked), 32'd1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("rst_locked", 32'(locked), 32'd0);
        checkOutput("rst_underflow", 32'(underflow), 32'd0);
        checkOutput("rst_de", 32'(de), 32'd0);
        checkOutput("rst_rgb", 32'(rgb), 32'd0);
        checkOutput("rst_hsync", 32'(hsync), 32'd1);
        checkOutput("rst_vsync", 32'(vsync), 32'd1);
        n = 0;
        while (!locked && n < 2 * FRAME) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        checkOutput("relock_delay", 32'(n), 32'(FRAME));
        for (int c = 0; c < 2 * HT; c++) applyStimulus(1'b0, 1'b0);

        for (int i = 0; i < NTBL; i++)
            checkOutput("tbl_visited", 32'(tbl_hits[i] > 0), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
